// File: rtl/mbist_pkg.sv
// Shared types for the MBIST control slice: the controller state encoding.
package mbist_pkg;

    // RESET holds the datapath in load/normal mode; TEST runs the self-test.
    typedef enum logic [0:0] {
        RESET = 1'b0,
        TEST  = 1'b1
    } mbist_state_t;

endpackage : mbist_pkg

// File: rtl/mbist_controller.sv
// Two-state Moore sequencer for an MBIST run. It sits above the address
// counter, pattern generator and comparator, and drives their mode select
// (NbarT) and load enable (ld). Outputs are decoded from the state flop only,
// so no input can reach an output combinationally.
module mbist_controller
    import mbist_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cout,
    output logic NbarT,
    output logic ld
);

    mbist_state_t state;
    mbist_state_t state_next;

    // State register; a synchronous reset returns to RESET from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start is only looked at in RESET and cout only in TEST.
    // A held start re-enters TEST straight after a run completes.
    always_comb begin
        state_next = state;
        case (state)
            RESET: if (start) state_next = TEST;
            TEST:  if (cout)  state_next = RESET;
            default: state_next = RESET;
        endcase
    end

    // Both outputs come straight off the state bit and are always inverses.
    assign NbarT = (state == TEST);
    assign ld    = (state == RESET);

`ifndef SYNTHESIS
    // Tracks whether the state has been initialised, so the output relation
    // is only checked once the flop holds a known value.
    logic reset_seen;

    // Sticky flag that sets on the first reset edge.
    always_ff @(posedge clk) begin
        reset_seen <= reset_seen | rst;
    end

    a_outputs_inverse : assert property (@(posedge clk)
        reset_seen |-> (ld == !NbarT));

    a_reset_to_reset : assert property (@(posedge clk)
        rst |=> (state == RESET));

    a_start_to_test : assert property (@(posedge clk)
        (reset_seen && state == RESET && start && !rst) |=> (state == TEST));

    a_cout_to_reset : assert property (@(posedge clk)
        (reset_seen && state == TEST && cout && !rst) |=> (state == RESET));
`endif

endmodule : mbist_controller

// File: tb/tb_mbist_controller.sv
// Self-checking bench for mbist_controller. A driver applies directed vectors
// on the falling edge and queues the hand-computed NbarT expected after the
// next rising edge; a monitor pops and compares just after each rising edge.
module tb_mbist_controller;

    logic clk;
    logic rst;
    logic start;
    logic cout;
    logic NbarT;
    logic ld;

    bit   exp_q[$];
    int   checks;
    int   errors;
    bit   drive_done;

    mbist_controller dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .cout  (cout),
        .NbarT (NbarT),
        .ld    (ld)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one vector for a single edge and queues the expected mode bit.
    task automatic applyStimulus(input bit r, input bit s, input bit c, input bit exp_nbart);
        @(negedge clk);
        rst   = r;
        start = s;
        cout  = c;
        exp_q.push_back(exp_nbart);
    endtask

    // Compares one observed value against its required value.
    task automatic checkOutput(input string name, input logic actual, input bit required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, required);
        end
    endtask

    // Monitor: one registered response per rising edge, sampled 1 unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            checkOutput("NbarT", NbarT, e);
            checkOutput("ld",    ld,    ~e);
        end
    end

    // Directed vectors: rst, start, cout, expected NbarT after the edge.
    initial begin
        checks     = 0;
        errors     = 0;
        drive_done = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        cout  = 1'b0;

        // Reset
        applyStimulus(1, 0, 0, 0);
        // Start, then hold in TEST with start low
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1);
        // Completion, then cout ignored in RESET
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        // Reset priority over a held start in TEST
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 1, 0, 0);
        // Back-to-back runs
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1);
        // Return to RESET, then simultaneous start and cout in each state
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 1, 0);
        // Held start re-enters TEST, then rst overrides everything
        applyStimulus(0, 1, 1, 1);
        applyStimulus(1, 1, 1, 0);
        // Held in RESET with rst still asserted and start high
        applyStimulus(1, 1, 0, 0);

        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        cout  = 1'b0;
        drive_done = 1'b1;
    end

    // Ends the run once the queue drains, within a fixed cycle budget.
    initial begin
        int cycles;
        cycles = 0;
        wait (drive_done);
        while (exp_q.size() > 0 && cycles < 20) begin
            @(posedge clk);
            cycles++;
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard limit so the run can never hang.
    initial begin
        #5000;
        $display("[TB] FAIL timeout: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_mbist_controller
